// File: rtl/ring_ro_seq.sv
// ring_ro_seq: multi-channel readout sequencer for the digitizer ring buffers.
// A start pulse captures the read window and channel mask. The block then
// streams read addresses for each enabled channel in ascending channel order,
// using a valid/ready handshake toward the serializer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i             readout request (sampled in IDLE only)
//   wr_addr_i           ring write pointer, sampled with start_i
//   offset_i            pretrigger depth; first address = wr_addr_i - offset_i
//   howmany_i           samples per channel (0 = nothing to read)
//   chan_mask_i         per-channel enable, sampled with start_i
//   rd_ready_i          downstream accepts current beat
//   rd_en_o             beat valid
//   rd_addr_o/rd_ch_o   beat address / channel (0 when idle)
//   last_o              final sample of the current channel
//   busy_o, done_o      sequencer busy, single-cycle completion pulse
//   abort_i, aborted_o  only with ROSEQ_ABORT_EN defined
//
// Build option: define ROSEQ_ABORT_EN to add abort_i / aborted_o.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | streaming beats for the current channel
// DONE  | one-cycle completion pulse, then back to IDLE
module ring_ro_seq #(
   parameter int AW  = 8,
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic [AW-1:0]  wr_addr_i,
   input  logic [AW-1:0]  offset_i,
   input  logic [AW-1:0]  howmany_i,
   input  logic [NCH-1:0] chan_mask_i,
   input  logic           rd_ready_i,
`ifdef ROSEQ_ABORT_EN
   input  logic           abort_i,
   output logic           aborted_o,
`endif
   output logic           rd_en_o,
   output logic [AW-1:0]  rd_addr_o,
   output logic [CHW-1:0] rd_ch_o,
   output logic           last_o,
   output logic           busy_o,
   output logic           done_o
);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t         r_state;
   logic [AW-1:0]  r_base;
   logic [AW-1:0]  r_cnt_init;
   logic [AW-1:0]  r_cnt;
   logic [NCH-1:0] r_mask;
   logic           r_rd_en;
   logic [AW-1:0]  r_rd_addr;
   logic [CHW-1:0] r_rd_ch;
   logic           r_last;
   logic           r_busy;
   logic           r_done;
   logic           r_aborted;

   logic [AW-1:0]  w_base;
   logic           w_xfer;
   logic           w_abort;
   logic           w_has_next;
   logic [CHW-1:0] w_next_ch;
   logic [CHW-1:0] w_first_ch;

   assign w_base = wr_addr_i - offset_i;
   assign w_xfer = r_rd_en & rd_ready_i;
`ifdef ROSEQ_ABORT_EN
   assign w_abort   = abort_i;
   assign aborted_o = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   // Descending scans so the final assignment is the lowest qualifying bit.
   always_comb begin
      w_has_next = 1'b0;
      w_next_ch  = '0;
      w_first_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_rd_ch))) begin
            w_has_next = 1'b1;
            w_next_ch  = CHW'(i);
         end
         if (chan_mask_i[i])
            w_first_ch = CHW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_cnt_init <= '0;
         r_cnt      <= '0;
         r_mask     <= '0;
         r_rd_en    <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_ch    <= '0;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_base     <= w_base;
                  r_cnt_init <= howmany_i;
                  r_mask     <= chan_mask_i;
                  r_busy     <= 1'b1;
                  if ((chan_mask_i == '0) || (howmany_i == '0)) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= READ;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= w_base;
                     r_rd_ch   <= w_first_ch;
                     r_cnt     <= howmany_i;
                     r_last    <= (howmany_i == AW'(1));
                  end
               end
            end
            READ: begin
               if (w_abort || (w_xfer && (r_cnt == AW'(1)) && !w_has_next)) begin
                  r_state   <= DONE;
                  r_rd_en   <= 1'b0;
                  r_rd_addr <= '0;
                  r_rd_ch   <= '0;
                  r_last    <= 1'b0;
                  r_done    <= 1'b1;
                  r_aborted <= w_abort;
               end else if (w_xfer) begin
                  if (r_cnt != AW'(1)) begin
                     r_rd_addr <= r_rd_addr + AW'(1);
                     r_cnt     <= r_cnt - AW'(1);
                     r_last    <= (r_cnt == AW'(2));
                  end else begin
                     // Channel switch without a bubble cycle.
                     r_rd_ch   <= w_next_ch;
                     r_rd_addr <= r_base;
                     r_cnt     <= r_cnt_init;
                     r_last    <= (r_cnt_init == AW'(1));
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_aborted <= 1'b0;
            end
         endcase
      end
   end

   assign rd_en_o   = r_rd_en;
   assign rd_addr_o = r_rd_addr;
   assign rd_ch_o   = r_rd_ch;
   assign last_o    = r_last;
   assign busy_o    = r_busy;
   assign done_o    = r_done;

endmodule

// File: tb/tb_ring_ro_seq.sv
module tb_ring_ro_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] wr_addr_i = '0;
   logic [7:0] offset_i = '0;
   logic [7:0] howmany_i = '0;
   logic [3:0] chan_mask_i = '0;
   logic       rd_ready_i = 1'b0;
   logic       rd_en_o;
   logic [7:0] rd_addr_o;
   logic [1:0] rd_ch_o;
   logic       last_o, busy_o, done_o;
`ifdef ROSEQ_ABORT_EN
   logic       abort_i = 1'b0;
   logic       aborted_o;
`endif

   always #5 clk = ~clk;

   ring_ro_seq #(.AW(8), .NCH(4), .CHW(2)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .wr_addr_i(wr_addr_i),
      .offset_i(offset_i), .howmany_i(howmany_i), .chan_mask_i(chan_mask_i),
      .rd_ready_i(rd_ready_i),
`ifdef ROSEQ_ABORT_EN
      .abort_i(abort_i), .aborted_o(aborted_o),
`endif
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_ch_o(rd_ch_o),
      .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
   );

   typedef struct {
      logic       rst, start;
      logic [7:0] wr, off, hm;
      logic [3:0] mask;
      logic       rdy;
      logic       en;
      logic [7:0] addr;
      logic [1:0] ch;
      logic       last, busy, done;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic void st(logic [7:0] wr, logic [7:0] off, logic [7:0] hm,
                              logic [3:0] mask, logic rdy, logic en, logic [7:0] addr,
                              logic [1:0] ch, logic last, logic busy, logic done);
      vec_t v;
      v = '{rst:1'b0, start:1'b1, wr:wr, off:off, hm:hm, mask:mask, rdy:rdy,
            en:en, addr:addr, ch:ch, last:last, busy:busy, done:done};
      vq.push_back(v);
   endfunction

   function automatic void cy(logic rdy, logic en, logic [7:0] addr, logic [1:0] ch,
                              logic last, logic busy, logic done);
      vec_t v;
      v = '{rst:1'b0, start:1'b0, wr:8'h00, off:8'h00, hm:8'h00, mask:4'h0, rdy:rdy,
            en:en, addr:addr, ch:ch, last:last, busy:busy, done:done};
      vq.push_back(v);
   endfunction

   function automatic void rs();
      vec_t v;
      v = '{rst:1'b1, start:1'b0, wr:8'h00, off:8'h00, hm:8'h00, mask:4'h0, rdy:1'b1,
            en:1'b0, addr:8'h00, ch:2'd0, last:1'b0, busy:1'b0, done:1'b0};
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start_i = 1'b0; wr_addr_i = '0; offset_i = '0;
      howmany_i = '0; chan_mask_i = '0; rd_ready_i = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int row);
      @(negedge clk);
      rst = v.rst; start_i = v.start; wr_addr_i = v.wr; offset_i = v.off;
      howmany_i = v.hm; chan_mask_i = v.mask; rd_ready_i = v.rdy;
      @(posedge clk);
      #1;
      check("rd_en",   row, 32'(rd_en_o),   32'(v.en));
      check("rd_addr", row, 32'(rd_addr_o), 32'(v.addr));
      check("rd_ch",   row, 32'(rd_ch_o),   32'(v.ch));
      check("last",    row, 32'(last_o),    32'(v.last));
      check("busy",    row, 32'(busy_o),    32'(v.busy));
      check("done",    row, 32'(done_o),    32'(v.done));
`ifdef ROSEQ_ABORT_EN
      check("aborted", row, 32'(aborted_o), 32'(0));
`endif
   endtask

   initial begin
      // reset
      rs();
      // single channel, 4 beats from 0x30
      st(8'h40, 8'h10, 8'd4, 4'b0001, 1, 1, 8'h30, 2'd0, 0, 1, 0);
      cy(1, 1, 8'h31, 0, 0, 1, 0);
      cy(1, 1, 8'h32, 0, 0, 1, 0);
      cy(1, 1, 8'h33, 0, 1, 1, 0);
      cy(1, 0, 8'h00, 0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // wrap across DEPTH
      st(8'h02, 8'h04, 8'd5, 4'b0001, 1, 1, 8'hFE, 2'd0, 0, 1, 0);
      cy(1, 1, 8'hFF, 0, 0, 1, 0);
      cy(1, 1, 8'h00, 0, 0, 1, 0);
      cy(1, 1, 8'h01, 0, 0, 1, 0);
      cy(1, 1, 8'h02, 0, 1, 1, 0);
      cy(1, 0, 8'h00, 0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // two channels, no gap on switch
      st(8'h90, 8'h10, 8'd3, 4'b1010, 1, 1, 8'h80, 2'd1, 0, 1, 0);
      cy(1, 1, 8'h81, 1, 0, 1, 0);
      cy(1, 1, 8'h82, 1, 1, 1, 0);
      cy(1, 1, 8'h80, 3, 0, 1, 0);
      cy(1, 1, 8'h81, 3, 0, 1, 0);
      cy(1, 1, 8'h82, 3, 1, 1, 0);
      cy(1, 0, 8'h00, 0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // stalls, start while busy and start during DONE ignored
      st(8'h20, 8'h00, 8'd3, 4'b0100, 0, 1, 8'h20, 2'd2, 0, 1, 0);
      st(8'h77, 8'h01, 8'd9, 4'b0001, 0, 1, 8'h20, 2'd2, 0, 1, 0);
      cy(0, 1, 8'h20, 2, 0, 1, 0);
      cy(1, 1, 8'h21, 2, 0, 1, 0);
      cy(0, 1, 8'h21, 2, 0, 1, 0);
      cy(1, 1, 8'h22, 2, 1, 1, 0);
      cy(0, 1, 8'h22, 2, 1, 1, 0);
      cy(1, 0, 8'h00, 0, 0, 1, 1);
      st(8'h10, 8'h00, 8'd2, 4'b0001, 1, 0, 8'h00, 2'd0, 0, 0, 0);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // one sample per channel, channels 0 and 3
      st(8'h05, 8'h00, 8'd1, 4'b1001, 1, 1, 8'h05, 2'd0, 1, 1, 0);
      cy(1, 1, 8'h05, 3, 1, 1, 0);
      cy(1, 0, 8'h00, 0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // empty mask, zero count
      st(8'h10, 8'h00, 8'd4, 4'b0000, 1, 0, 8'h00, 2'd0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      st(8'h10, 8'h00, 8'd0, 4'b1111, 1, 0, 8'h00, 2'd0, 0, 1, 1);
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      // reset mid-readout
      st(8'h10, 8'h00, 8'd8, 4'b0001, 1, 1, 8'h10, 2'd0, 0, 1, 0);
      cy(1, 1, 8'h11, 0, 0, 1, 0);
      rs();
      cy(1, 0, 8'h00, 0, 0, 0, 0);
      cy(1, 0, 8'h00, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // all four channels, random stalls, wrap inside each channel
      begin
         int k = 0;
         bit got_done = 1'b0;
         @(negedge clk);
         start_i = 1'b1; wr_addr_i = 8'h01; offset_i = 8'h03;
         howmany_i = 8'd3; chan_mask_i = 4'b1111; rd_ready_i = 1'b0;
         @(negedge clk);
         idle_inputs();
         for (int c = 0; c < 300 && !got_done; c++) begin
            if (done_o) begin
               got_done = 1'b1;
            end else begin
               if (rd_en_o) begin
                  check("rnd_addr", k, 32'(rd_addr_o), 32'(8'(8'hFE + 8'(k % 3))));
                  check("rnd_ch",   k, 32'(rd_ch_o),   32'(k / 3));
                  check("rnd_last", k, 32'(last_o),    32'((k % 3) == 2));
               end
               rd_ready_i = 1'($urandom_range(0, 1));
               if (rd_en_o && rd_ready_i) k++;
               @(negedge clk);
            end
         end
         check("rnd_done_seen", 0, 32'(got_done), 32'(1));
         check("rnd_beats", 0, 32'(k), 32'(12));
         idle_inputs();
         @(negedge clk);
         check("rnd_busy_after", 0, 32'(busy_o), 32'(0));
      end

`ifdef ROSEQ_ABORT_EN
      // abort on third beat of eight
      @(negedge clk);
      start_i = 1'b1; wr_addr_i = 8'h00; offset_i = 8'h00;
      howmany_i = 8'd8; chan_mask_i = 4'b0001; rd_ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("ab_beat0", 0, 32'(rd_addr_o), 32'(8'h00));
      @(negedge clk);
      check("ab_beat1", 0, 32'(rd_addr_o), 32'(8'h01));
      @(negedge clk);
      check("ab_beat2", 0, 32'(rd_addr_o), 32'(8'h02));
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("ab_en",      0, 32'(rd_en_o),   32'(0));
      check("ab_done",    0, 32'(done_o),    32'(1));
      check("ab_aborted", 0, 32'(aborted_o), 32'(1));
      @(negedge clk);
      check("ab_aborted_clr", 0, 32'(aborted_o), 32'(0));
      check("ab_busy_clr",    0, 32'(busy_o),    32'(0));
      start_i = 1'b1; howmany_i = 8'd2;
      @(negedge clk);
      start_i = 1'b0;
      check("ab2_beat0", 0, 32'(rd_addr_o), 32'(8'h00));
      @(negedge clk);
      check("ab2_beat1", 0, 32'(last_o), 32'(1));
      @(negedge clk);
      check("ab2_done",    0, 32'(done_o),    32'(1));
      check("ab2_aborted", 0, 32'(aborted_o), 32'(0));
      idle_inputs();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
